// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling block.
package rc4_pkg;
  localparam int S_DEPTH = 256;
  localparam int KEY_W   = 24;

  typedef enum logic [2:0] {
    INIT, RD_I, LATCH_I, RD_J, LATCH_J, WR_I, WR_J, DONE
  } state_t;

  // Hex digit to active-low segment pattern, bit0=a .. bit6=g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/s_memory.sv
// 256x8 single-port synchronous RAM holding the RC4 state array.
module s_memory
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       wren,
  output logic [7:0] q
);
  logic [7:0] mem [0:S_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wren) mem[addr] <= data;
    q <= mem[addr];
  end
endmodule

// File: rtl/rc4_ksa.sv
// RC4 key scheduling over a 256-byte S array; key from switches, shown on HEX.
module rc4_ksa
  import rc4_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);
  logic clk, rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[3];

  logic unused_keys;
  assign unused_keys = &{1'b0, KEY[2:0]};

  state_t           state, state_nx;
  logic [7:0]       i, j, si, sj;
  logic [1:0]       kidx;
  logic [KEY_W-1:0] key_q, secret;
  logic [7:0]       kb;
  logic [7:0]       addr, data, q;
  logic             wren, busy, done;

  assign secret = {14'b0, SW};

  // kidx tracks i mod 3 so no divider is needed
  always_comb begin
    case (kidx)
      2'd0:    kb = key_q[23:16];
      2'd1:    kb = key_q[15:8];
      default: kb = key_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (i == 8'hFF) state_nx = RD_I;
      RD_I:    state_nx = LATCH_I;
      LATCH_I: state_nx = RD_J;
      RD_J:    state_nx = LATCH_J;
      LATCH_J: state_nx = WR_I;
      WR_I:    state_nx = WR_J;
      WR_J:    state_nx = (i == 8'hFF) ? DONE : RD_I;
      default: state_nx = DONE;
    endcase
  end

  always_comb begin
    addr = i;
    data = i;
    wren = 1'b0;
    case (state)
      INIT: wren = 1'b1;
      RD_J: addr = j;
      WR_I: begin data = sj; wren = 1'b1; end
      WR_J: begin addr = j; data = si; wren = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
      key_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state_nx != DONE);
      done <= (state_nx == DONE);
      case (state)
        // i wraps 255->0 naturally, leaving the KSA phase starting at i=0
        INIT: begin
          key_q <= secret;
          i     <= i + 8'd1;
          j     <= '0;
          kidx  <= '0;
        end
        LATCH_I: begin
          si <= q;
          j  <= j + q + kb;
        end
        LATCH_J: sj <= q;
        WR_J: if (i != 8'hFF) begin
          i    <= i + 8'd1;
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  s_memory u_mem (
    .clk  (clk),
    .addr (addr),
    .data (data),
    .wren (wren),
    .q    (q)
  );

  assign LEDR = {8'b0, busy, done};
  assign HEX0 = seg7(key_q[3:0]);
  assign HEX1 = seg7(key_q[7:4]);
  assign HEX2 = seg7(key_q[11:8]);
  assign HEX3 = seg7(key_q[15:12]);
  assign HEX4 = seg7(key_q[19:16]);
  assign HEX5 = seg7(key_q[23:20]);
endmodule

// File: tb/tb_rc4_ksa.sv
// Directed bench for rc4_ksa: timing, partial and full S contents, reset abort.
module tb_rc4_ksa;
  import rc4_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'b0111;
  logic [9:0] SW = '0;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_s [256];
  int first_bad;

  localparam logic [41:0] HEX_ZERO = {6{7'h40}};

  always #10 CLOCK_50 = ~CLOCK_50;

  rc4_ksa dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .LEDR     (LEDR),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5)
  );

  function automatic logic [41:0] hex_all();
    return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  // Reference RC4 KSA with a 3-byte key
  task automatic model_ksa(input logic [23:0] key);
    int jj;
    logic [7:0] t, kbv;
    for (int k = 0; k < 256; k++) exp_s[k] = k[7:0];
    jj = 0;
    for (int ii = 0; ii < 256; ii++) begin
      case (ii % 3)
        0:       kbv = key[23:16];
        1:       kbv = key[15:8];
        default: kbv = key[7:0];
      endcase
      jj = (jj + int'(exp_s[ii]) + int'(kbv)) % 256;
      t = exp_s[ii]; exp_s[ii] = exp_s[jj]; exp_s[jj] = t;
    end
  endtask

  function automatic int s_diffs();
    int n = 0;
    first_bad = -1;
    for (int k = 0; k < 256; k++)
      if (dut.u_mem.mem[k] !== exp_s[k]) begin
        n++;
        if (first_bad < 0) first_bad = k;
      end
    return n;
  endfunction

  task automatic do_reset(input logic [9:0] sw);
    @(negedge CLOCK_50);
    KEY = 4'b0111;
    SW  = sw;
    repeat (3) @(negedge CLOCK_50);
    KEY = 4'b1111;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    total++;
    if (LEDR !== 10'h000) begin
      bad++; $display("FAIL reset_ledr got=%h want=000", LEDR);
    end
    total++;
    if (hex_all() !== HEX_ZERO) begin
      bad++; $display("FAIL reset_hex got=%h want=%h", hex_all(), HEX_ZERO);
    end
  endtask

  task automatic test_key0();
    int n;
    logic [7:0] v [4];
    do_reset(10'h000);
    model_ksa(24'h000000);
    for (int e = 1; e <= 1792; e++) begin
      step(1);
      if (e < 1792) begin
        total++;
        if (LEDR[1:0] !== 2'b10) begin
          bad++; $display("FAIL k0_busy edge=%0d got=%b want=10", e, LEDR[1:0]);
        end
      end
      if (e == 256) begin
        n = 0;
        for (int k = 0; k < 256; k++) if (dut.u_mem.mem[k] !== k[7:0]) n++;
        total++;
        if (n !== 0) begin
          bad++; $display("FAIL k0_init bad_entries=%0d want=0", n);
        end
      end
      if (e == 274) begin
        for (int k = 0; k < 4; k++) v[k] = dut.u_mem.mem[k];
        total++;
        if ({v[0], v[1], v[2], v[3]} !== 32'h00010302) begin
          bad++; $display("FAIL k0_iter3 got=%h%h%h%h want=00010302", v[0], v[1], v[2], v[3]);
        end
      end
    end
    total++;
    if (LEDR !== 10'h001) begin
      bad++; $display("FAIL k0_done got=%h want=001", LEDR);
    end
    n = s_diffs();
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL k0_final bad_entries=%0d first=%0d want=0", n, first_bad);
    end
    for (int c = 0; c < 30; c++) begin
      step(1);
      total++;
      if (dut.wren !== 1'b0 || LEDR !== 10'h001) begin
        bad++; $display("FAIL k0_idle cycle=%0d wren=%b ledr=%h want wren=0 ledr=001", c, dut.wren, LEDR);
      end
    end
  endtask

  task automatic test_key249();
    int n;
    logic [7:0] v [5];
    do_reset(10'h249);
    model_ksa(24'h000249);
    step(1);
    total++;
    if (hex_all() !== {7'h40, 7'h40, 7'h40, 7'h24, 7'h19, 7'h10}) begin
      bad++; $display("FAIL k249_hex got=%h want=%h", hex_all(), {7'h40, 7'h40, 7'h40, 7'h24, 7'h19, 7'h10});
    end
    step(273);
    v[0] = dut.u_mem.mem[0];
    v[1] = dut.u_mem.mem[1];
    v[2] = dut.u_mem.mem[3];
    v[3] = dut.u_mem.mem[2];
    v[4] = dut.u_mem.mem[8'h4E];
    total++;
    if ({v[0], v[1], v[2], v[3], v[4]} !== 40'h00_03_01_4E_02) begin
      bad++; $display("FAIL k249_iter3 got=%h%h%h%h%h want=0003014e02", v[0], v[1], v[2], v[3], v[4]);
    end
    step(1792 - 274);
    total++;
    if (LEDR[1:0] !== 2'b01) begin
      bad++; $display("FAIL k249_done got=%b want=01", LEDR[1:0]);
    end
    n = s_diffs();
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL k249_final bad_entries=%0d first=%0d want=0", n, first_bad);
    end
  endtask

  task automatic test_abort();
    int n;
    do_reset(10'h000);
    step(900);
    #3;
    KEY = 4'b0111;
    #1;
    total++;
    if (LEDR !== 10'h000 || hex_all() !== HEX_ZERO) begin
      bad++; $display("FAIL abort_async ledr=%h hex=%h want ledr=000 hex=%h", LEDR, hex_all(), HEX_ZERO);
    end
    total++;
    if (dut.state !== INIT) begin
      bad++; $display("FAIL abort_state got=%0d want=%0d", dut.state, INIT);
    end
    do_reset(10'h3FF);
    model_ksa(24'h0003FF);
    step(1791);
    total++;
    if (LEDR[1:0] !== 2'b10) begin
      bad++; $display("FAIL abort_1791 got=%b want=10", LEDR[1:0]);
    end
    step(1);
    total++;
    if (LEDR[1:0] !== 2'b01) begin
      bad++; $display("FAIL abort_1792 got=%b want=01", LEDR[1:0]);
    end
    total++;
    if (hex_all() !== {7'h40, 7'h40, 7'h40, 7'h30, 7'h0E, 7'h0E}) begin
      bad++; $display("FAIL abort_hex got=%h want=%h", hex_all(), {7'h40, 7'h40, 7'h40, 7'h30, 7'h0E, 7'h0E});
    end
    n = s_diffs();
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL abort_final bad_entries=%0d first=%0d want=0", n, first_bad);
    end
  endtask

  task automatic test_sw_change();
    int n;
    do_reset(10'h155);
    model_ksa(24'h000155);
    step(500);
    SW = 10'h2AA;
    step(1);
    total++;
    if (hex_all() !== {7'h40, 7'h40, 7'h40, 7'h79, 7'h12, 7'h12}) begin
      bad++; $display("FAIL swchg_hex got=%h want=%h", hex_all(), {7'h40, 7'h40, 7'h40, 7'h79, 7'h12, 7'h12});
    end
    step(1291);
    total++;
    if (LEDR[1:0] !== 2'b01) begin
      bad++; $display("FAIL swchg_done got=%b want=01", LEDR[1:0]);
    end
    n = s_diffs();
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL swchg_final bad_entries=%0d first=%0d want=0", n, first_bad);
    end
  endtask

  initial begin
    test_reset();
    test_key0();
    test_key249();
    test_abort();
    test_sw_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rc4_ksa.md
Name: rc4_ksa

Overview:
- Top-level board block that runs the RC4 Key Scheduling Algorithm on a 256-byte state array S.
- The 24-bit secret key is formed from the slide switches.
- Displays the key on six seven-segment digits and reports busy/done on LEDs.
- Runs automatically after reset; a later decrypt stage will reuse S.

Parameters:
- None. The state array is fixed at 256×8 and the key at 24 bits (3 bytes).

Ports:
- CLOCK_50  input   1   system clock, all logic on rising edge
- KEY       input   4   KEY[3] = reset_n: asynchronous, active-low; KEY[2:0] unused
- SW        input   10  low 10 bits of secret key
- LEDR      output  10  [0]=done, [1]=busy, [9:2]=0
- HEX0..HEX5 output 7 each  active-low seven-segment digits (segment bit0=a … bit6=g)

Behaviour:
- One clock (CLOCK_50). Reset KEY[3] is asynchronous, active-low.
- While reset is low:
  - state=INIT, i=0, j=0, key register=0, si=sj=0.
  - LEDR=0; HEX show "0" on all digits.
- Reset asserted mid-operation aborts immediately. After release, the block restarts from INIT and rewrites all of S.
- Secret key: secret = {14'b0, SW}.
  - key register loads secret every cycle in INIT and holds it from the first KSA cycle to DONE.
  - Key bytes: kb[0]=secret[23:16], kb[1]=secret[15:8], kb[2]=secret[7:0].
  - Byte for index i is kb[i mod 3].
- S memory: 256×8 single-port synchronous RAM.
  - Address, data and write-enable are driven combinationally from the FSM.
  - A write commits at the clock edge.
  - Read data q is valid in the cycle after the address was presented.
- FSM, one state per cycle:
  - INIT: write S[i]=i; i++. At i==255, go to RD_I with i=0, j=0. Takes 256 cycles.
  - RD_I: addr=i, no write.
  - LATCH_I: si<=q; j<=j+q+kb[i mod 3], mod 256 (8-bit wrap).
  - RD_J: addr=j (the updated j).
  - LATCH_J: sj<=q.
  - WR_I: write S[i]=sj.
  - WR_J: write S[j]=si. If i==255 go to DONE, else i++ and go to RD_I.
  - DONE: holds forever until reset; no memory writes.
- i==j is legal: both writes store the original value, so S is unchanged.
- i mod 3 comes from a 2-bit counter cycling 0,1,2, reset to 0 when the KSA phase starts. No divider.
- Latency: 256 + 256×6 = 1792 cycles. DONE is entered on the 1792nd rising edge after reset release.
- LEDR[1]=1 in every state except DONE; LEDR[0]=1 only in DONE; both registered.
- HEX5..HEX0 show key register nibbles [23:20]..[3:0] as hex 0–F (standard 7-seg patterns, active-low). Combinational from the key register.

Decomposition:
- Package rc4_pkg holds:
  - state enum (INIT, RD_I, LATCH_I, RD_J, LATCH_J, WR_I, WR_J, DONE)
  - S_DEPTH=256, KEY_W=24
  - seven-segment decode function
- Sub-module s_memory: 256×8 sync RAM, ports clk, addr[7:0], data[7:0], wren, q[7:0]. Internal array named mem so benches can peek it hierarchically.
- FSM, key register and display logic live in rc4_ksa.

Test Plan:
- Reset then SW=0, run 1792 cycles:
  - LEDR[0]=1, LEDR[1]=0.
  - mem[0]=0, mem[1]=1, mem[2]=3, mem[3]=2 after the first 3 iterations.
  - Full S matches a software RC4 KSA for key 00 00 00.
- SW=10'h249:
  - HEX5..HEX0 show 0,0,0,2,4,9.
  - After INIT plus 3 iterations (256+18 cycles): mem[0]=0x00, mem[1]=0x03, mem[3]=0x01, mem[2]=0x4E, mem[0x4E]=0x02.
  - Final S equals the software model.
- Cycle check after reset release:
  - LEDR[1]=1 and LEDR[0]=0 through edge 1791.
  - LEDR[0]=1 at edge 1792.
  - No wren is asserted afterwards.
- INIT check at cycle 256: mem[k]=k for all k; busy=1.
- Assert KEY[3]=0 at cycle 900, change SW to 10'h3FF, release:
  - Outputs go to reset values immediately (asynchronously).
  - The rerun takes 1792 cycles and S equals the model for key 00 03 FF.
- Change SW during KSA (cycle 500): key register and HEX unchanged; final S uses the key captured in INIT.
